// File: rtl/num_display_scan.sv
// Multiplexed 7-segment driver: captures a calculator number and scans its BCD digits
// onto one shared segment bus, handling decimal point, leading-zero blanking, sign and error.
package calc_pkg;
    localparam int NumDigits = 8;
    localparam int ExpW      = $clog2(NumDigits);

    typedef struct packed {
        logic                        error;
        logic                        sign;
        logic [ExpW-1:0]             exponent;
        logic [NumDigits-1:0][3:0]   significand;
    } num_t;

    // Segment order {a,b,c,d,e,f,g} on bits 6..0; anything that is not a BCD digit is dark.
    function automatic logic [6:0] bcd2segments(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction
endpackage

module num_display_scan #(
    parameter int ClkDiv = 1000
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  calc_pkg::num_t                 num_i,
    input  logic                           load_i,
    input  logic                           blank_i,
    output logic [6:0]                     segments_o,
    output logic                           dp_o,
    output logic [calc_pkg::NumDigits-1:0] digit_en_o,
    output logic                           minus_o
);
    localparam int NumDigits = calc_pkg::NumDigits;
    localparam int IdxW      = $clog2(NumDigits);
    localparam int DivW      = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(ClkDiv - 1);
    localparam logic [IdxW-1:0] IdxMax = IdxW'(NumDigits - 1);
    localparam logic [6:0]      SegE   = 7'b1001111;

    calc_pkg::num_t    r_shadow;
    logic              r_blank;
    logic [DivW-1:0]   r_div;
    logic [IdxW-1:0]   r_idx;

    logic [3:0]            w_digit;
    logic                  w_upperNonZero;
    logic                  w_leadBlank;
    logic [6:0]            w_seg;
    logic                  w_dp;
    logic                  w_minus;
    logic [NumDigits-1:0]  w_en;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_shadow <= '0;
            r_blank  <= 1'b0;
            r_div    <= '0;
            r_idx    <= '0;
        end else begin
            if (load_i) begin
                r_shadow <= num_i;
            end
            r_blank <= blank_i;
            if (r_div == DivMax) begin
                r_div <= '0;
                r_idx <= (r_idx == IdxMax) ? '0 : r_idx + 1'b1;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    // A digit is a leading zero only if it and every more significant digit are zero.
    always_comb begin
        w_upperNonZero = 1'b0;
        for (int j = 0; j < NumDigits; j++) begin
            if (j >= int'(r_idx) && r_shadow.significand[j] != 4'd0) begin
                w_upperNonZero = 1'b1;
            end
        end
    end

    always_comb begin
        w_digit     = r_shadow.significand[r_idx];
        w_leadBlank = (r_idx > r_shadow.exponent) && !w_upperNonZero;
        w_en        = NumDigits'(1) << r_idx;
        w_minus     = r_shadow.sign && !r_shadow.error && (r_shadow.significand != '0);
        w_seg       = '0;
        w_dp        = 1'b0;
        if (r_shadow.error) begin
            w_seg = (r_idx == '0) ? SegE : 7'b0000000;
        end else if (!w_leadBlank) begin
            w_seg = calc_pkg::bcd2segments(w_digit);
            w_dp  = (r_idx == r_shadow.exponent);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            segments_o <= '0;
            dp_o       <= 1'b0;
            digit_en_o <= '0;
            minus_o    <= 1'b0;
        end else if (r_blank) begin
            segments_o <= '0;
            dp_o       <= 1'b0;
            digit_en_o <= '0;
            minus_o    <= 1'b0;
        end else begin
            segments_o <= w_seg;
            dp_o       <= w_dp;
            digit_en_o <= w_en;
            minus_o    <= w_minus;
        end
    end
endmodule

// File: doc/num_display_scan.md
# num_display_scan

Time-multiplexed 7-segment display driver for the calculator. It captures a `num_t` from the datapath and scans its `NumDigits` BCD digits onto one shared segment bus, one digit at a time. It handles the decimal point from `exponent`, leading-zero blanking, the sign indicator and the error glyph. It is the output end of the `num_t` interface: the datapath produces numbers, and this block consumes and renders them.

## Interface
- `ClkDiv`, default 1000: clock cycles each digit stays enabled; legal range ≥1.
- `NumDigits`, fixed by `calc_pkg` (8): number of scanned digits.
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, asynchronous and active-high.
- `num_i` in `$bits(num_t)`: number to display, as `calc_pkg::num_t`.
- `load_i` in 1: when high, `num_i` is captured into the shadow register on this edge.
- `blank_i` in 1: when high, forces all display outputs low; scanning continues.
- `segments_o` out 7: segments {6..0} of the active digit, using the `bcd2segments` bit order, active-high.
- `dp_o` out 1: decimal point of the active digit.
- `digit_en_o` out `NumDigits`: one-hot enable of the active digit; bit 0 is the rightmost digit.
- `minus_o` out 1: dedicated minus annunciator.

## Operation
- **Shadow register.**
  - Holds `num_t`; reset value is all zeros.
  - Loaded whenever `load_i`=1. `num_i` is ignored otherwise.
- **Divider counter.**
  - Width `$clog2(ClkDiv)`, minimum 1 bit.
  - Counts 0..ClkDiv-1 and wraps to 0.
- **Digit index.**
  - Width `$clog2(NumDigits)`.
  - Increments when the divider is at ClkDiv-1; wraps from NumDigits-1 to 0.
  - With ClkDiv=1 it advances every cycle.
- **Digit value.** Digit i = `significand[i]`. The decimal point sits on digit `exponent` (value = significand / 10^exponent). Exponent 0 lights dp on digit 0.
- **Leading-zero blanking.**
  - Digit i is blank when i > exponent and `significand[j]`==0 for all j ≥ i.
  - Digit 0 and every digit ≤ exponent are never blanked.
  - A blank digit drives segments=0 and dp=0, but `digit_en_o` stays asserted.
- **Error.**
  - When `error`=1, digit 0 shows "E" (7'b1001111).
  - All other digits are blank, dp is 0 everywhere and `minus_o`=0.
  - Significand, sign and exponent are ignored.
- **Sign.** `minus_o` = sign & ~error & (significand != 0). Negative zero shows no minus.
- **Invalid BCD.** A digit value >9 in a non-blank position drives segments=0. It must not propagate X.
- **Blank input.** With `blank_i`=1, `segments_o`, `dp_o`, `digit_en_o` and `minus_o` are all 0. The divider, index and shadow register keep operating.

## Timing
- All outputs are registered. On reset every output is 0, the divider is 0 and the index is 0.
- **First cycle after reset release.** The first rising edge after `rst_i` falls registers digit 0 of the zero shadow:
  - `digit_en_o`=00000001
  - `segments_o`=1111110
  - `dp_o`=1
  - `minus_o`=0
- **Load latency.** `load_i` on edge N updates the shadow; outputs reflect the new value after edge N+1. Exactly one digit slot shows the new value 2 cycles after `load_i`.
- **Load mid-scan.** The divider and index are not reset. Scan phase is independent of loads.
- **Back-to-back loads.** The last one wins; no handshake, no backpressure.
- **Blank latency.** `blank_i` is registered like the data: it takes effect on the edge after it is sampled and releases the same way.
- **Full frame.** A frame is NumDigits×ClkDiv cycles. Each digit is enabled for exactly ClkDiv consecutive cycles.
- **`digit_en_o` invariants.**
  - Never has more than one bit set.
  - When not blanked, it has exactly one bit set.
- **Asynchronous reset mid-scan.** Reset immediately zeroes all outputs and state, including the shadow. After release, scanning restarts at digit 0.

## Test plan
- **Reset release.** ClkDiv=4, reset then release → `digit_en_o` walks 01,02,04…80,01, each held 4 cycles. Digit 0 shows 1111110 with dp=1; digits 1–7 show segments=0.
- **Integer with blanking.** Load significand 0x00001203, exp=0, sign=0 →
  - digit0=1111001 (3), dp=1
  - digit1=1111110 (0)
  - digit2=1101101 (2)
  - digit3=0110000 (1)
  - digits 4–7 segments=0
  - `minus_o`=0
- **Decimal point and zero padding.** Load 0x00000005, exp=3, sign=1 →
  - digit0 = 5 (1011011)
  - digits 1–3 show 0 (1111110), unblanked
  - dp only on digit3
  - digits 4–7 blank
  - `minus_o`=1
- **Error glyph.** Load `error`=1, significand 0x87654321 → digit0=1001111, all other digits segments=0, dp=0 everywhere, `minus_o`=0.
- **Negative zero.** Load sign=1 with zero significand → `minus_o`=0 and digit0=1111110.
- **Load and blank latency.** Assert `load_i` one cycle, then `blank_i` for 3 cycles →
  - New value visible 2 cycles after `load_i`.
  - All outputs 0 for 3 cycles starting one cycle after `blank_i` rises.
  - Scan index continuity is preserved.
  - An asynchronous `rst_i` pulse mid-digit zeroes outputs within the same cycle.
